// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter register and fetch sequencer. It drives pc_out to the
//   external incrementer and to the instruction-memory address port. It takes
//   pc_out + 4 back on incr_in as the sequential next PC.
//   The target is chosen from sequential, branch, jump or exception vector.
//   Every redirect inserts one bubble cycle before the target is fetched.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   incr_in        pc_out + 4 from the external incrementer
//   stall          downstream stall, blocks fetch acceptance
//   branch_taken   branch redirect request, with branch_target
//   jump           jump redirect request, with jump_target (wins over branch)
//   imem_ready     instruction memory can take the address this cycle
//   pc_out         current PC / fetch address
//   fetch_valid    pc_out is a valid fetch request
//   misalign       sticky: a misaligned redirect target was trapped
//   fetch_count    accepted-fetch counter, wraps silently
module pc_fetch_ctrl #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] incr_in,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             imem_ready,
   output logic [WIDTH-1:0] pc_out,
   output logic             fetch_valid,
   output logic             misalign,
   output logic [15:0]      fetch_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] next_pc;
   logic             next_misalign;
   logic [15:0]      next_count;

   logic             redirect;
   logic [WIDTH-1:0] target;
   logic             accept;

   assign redirect = jump | branch_taken;
   // jump has priority; a simultaneous branch is dropped
   assign target   = jump ? jump_target : branch_target;

   // Only the state decides fetch_valid. stall and imem_ready only gate
   // acceptance. BUBBLE is never valid, so no fetch is accepted during it.
   assign fetch_valid = (state == RUN);
   assign accept      = fetch_valid & imem_ready & ~stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc_out      <= RESET_PC;
         misalign    <= 1'b0;
         fetch_count <= 16'h0000;
      end else begin
         state       <= next_state;
         pc_out      <= next_pc;
         misalign    <= next_misalign;
         fetch_count <= next_count;
      end
   end

   always_comb begin
      next_state    = state;
      next_pc       = pc_out;
      next_misalign = misalign;
      next_count    = fetch_count;
      case (state)
         // IDLE ignores redirects and always moves on to RUN
         IDLE: next_state = RUN;
         RUN, BUBBLE: begin
            if (redirect) begin
               // A redirect overrides stall/imem_ready and any fetch in the
               // same cycle. In BUBBLE the newer target replaces the pending one.
               next_state = BUBBLE;
               if (target[1:0] != 2'b00) begin
                  next_pc       = EXC_VECTOR;
                  next_misalign = 1'b1;
               end else begin
                  next_pc = target;
               end
            end else if (accept) begin
               next_pc    = incr_in;
               next_count = fetch_count + 16'd1;
            end else begin
               // RUN holds while blocked. BUBBLE already holds the target,
               // so it goes to RUN.
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
